// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the mem_arbiter slice: bus widths, FSM state
// encoding and the burst-counter width helper.
package mem_arbiter_pkg;

  localparam int unsigned AW = 7;   // memory address width
  localparam int unsigned DW = 16;  // memory word width

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  // Bits needed to hold 0..max_burst inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every requester-side and memory-side signal of mem_arbiter.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester access requests
//   gnt0/gnt1, rvalid0/rvalid1, rdata              : arbiter responses
//   mem_addr, mem_we, mem_wdata, mem_rdata         : single-port memory pins
// Modports:
//   slave  - the arbiter's view
//   master - the surrounding system (requesters + memory)
interface mem_arbiter_if;

  logic                          req0;
  logic                          req1;
  logic                          we0;
  logic                          we1;
  logic [mem_arbiter_pkg::AW-1:0] addr0;
  logic [mem_arbiter_pkg::AW-1:0] addr1;
  logic [mem_arbiter_pkg::DW-1:0] wdata0;
  logic [mem_arbiter_pkg::DW-1:0] wdata1;
  logic                          gnt0;
  logic                          gnt1;
  logic                          rvalid0;
  logic                          rvalid1;
  logic [mem_arbiter_pkg::DW-1:0] rdata;
  logic [mem_arbiter_pkg::AW-1:0] mem_addr;
  logic                          mem_we;
  logic [mem_arbiter_pkg::DW-1:0] mem_wdata;
  logic [mem_arbiter_pkg::DW-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_we, mem_wdata
  );

endinterface

// File: rtl/arb_burst_ctr.sv
// Saturating burst counter for mem_arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count one access
//   count      : current count, saturates at MAX_BURST
//   tc         : count == MAX_BURST
//   tc_next    : count will be (or already is) MAX_BURST after this cycle's
//                access; independent of clr so the FSM can use it to decide clr
module arb_burst_ctr #(
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned CW        = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic          tc,
  output logic          tc_next
);

  localparam logic [CW-1:0] MAXV  = CW'(MAX_BURST);
  localparam logic [CW-1:0] MAXM1 = CW'(MAX_BURST - 1);

  assign tc      = (count == MAXV);
  assign tc_next = tc | (inc & (count == MAXM1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between
// requester 0 (processor) and requester 1 (host loader / debug). An owner
// keeps the grant for up to MAX_BURST accesses while the other side waits,
// then hands over directly with no idle cycle.
//   clk   : clock, all state on rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_arbiter_if.slave, requester and memory pins
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CW = cnt_width(MAX_BURST);

  arb_state_e    state;
  arb_state_e    state_d;
  logic          last_served;
  logic          last_d;
  logic          clr;
  logic          acc0;
  logic          acc1;
  logic [CW-1:0] count;
  logic          tc;
  logic          tc_next;

  assign acc0 = (state == OWN0) & bus.req0;
  assign acc1 = (state == OWN1) & bus.req1;

  arb_burst_ctr #(
    .MAX_BURST (MAX_BURST),
    .CW        (CW)
  ) u_ctr (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .inc     (acc0 | acc1),
    .count   (count),
    .tc      (tc),
    .tc_next (tc_next)
  );

  // Next-state: the counter is cleared whenever ownership changes or is idle.
  always_comb begin
    state_d = state;
    last_d  = last_served;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (bus.req0 && !bus.req1)      state_d = OWN0;
        else if (bus.req1 && !bus.req0) state_d = OWN1;
        else if (bus.req0 && bus.req1)  state_d = last_served ? OWN0 : OWN1;
      end
      OWN0: begin
        if (!bus.req0) begin
          state_d = bus.req1 ? OWN1 : IDLE;
          last_d  = 1'b0;
          clr     = 1'b1;
        end else if (tc_next && bus.req1) begin
          state_d = OWN1;
          last_d  = 1'b0;
          clr     = 1'b1;
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? OWN0 : IDLE;
          last_d  = 1'b1;
          clr     = 1'b1;
        end else if (tc_next && bus.req0) begin
          state_d = OWN0;
          last_d  = 1'b1;
          clr     = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
      end
    endcase
  end

  // Grants are registered copies of the next state so they change on the
  // same edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
      bus.gnt0    <= 1'b0;
      bus.gnt1    <= 1'b0;
      bus.rvalid0 <= 1'b0;
      bus.rvalid1 <= 1'b0;
    end else begin
      state       <= state_d;
      last_served <= last_d;
      bus.gnt0    <= (state_d == OWN0);
      bus.gnt1    <= (state_d == OWN1);
      bus.rvalid0 <= acc0 & ~bus.we0;
      bus.rvalid1 <= acc1 & ~bus.we1;
    end
  end

  // Address/data follow the owner even when its req is low; mem_we only
  // asserts in a real access cycle.
  always_comb begin
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    unique case (state)
      OWN0: begin
        bus.mem_addr  = bus.addr0;
        bus.mem_wdata = bus.wdata0;
        bus.mem_we    = acc0 & bus.we0;
      end
      OWN1: begin
        bus.mem_addr  = bus.addr1;
        bus.mem_wdata = bus.wdata1;
        bus.mem_we    = acc1 & bus.we1;
      end
      default: ;
    endcase
  end

  assign bus.rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] mem [0:127];

  mem_arbiter_if bus();

  mem_arbiter #(.MAX_BURST(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory model, 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.we0  = 1'b0; bus.we1  = 1'b0;
    bus.addr0 = '0;  bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'(16'hA000 + i);
    mem[5] = 16'hBEEF;
    idle_inputs();
    tick();
    tick();

    // Reset state
    chk("rst_gnt0",    32'(bus.gnt0), 0);
    chk("rst_gnt1",    32'(bus.gnt1), 0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 0);
    chk("rst_mem_we",  32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);

    // 1: single read by requester 0
    reset = 1'b1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 7'h05;
    tick();
    chk("t1_gnt0", 32'(bus.gnt0), 1);
    chk("t1_gnt1", 32'(bus.gnt1), 0);
    chk("t1_mem_addr", 32'(bus.mem_addr), 32'h05);
    chk("t1_mem_we", 32'(bus.mem_we), 0);
    tick();
    chk("t1_rvalid0", 32'(bus.rvalid0), 1);
    chk("t1_rdata", 32'(bus.rdata), 32'hBEEF);
    chk("t1_rvalid1", 32'(bus.rvalid1), 0);
    bus.req0 = 1'b0;
    tick();
    chk("t1_gnt0_rel", 32'(bus.gnt0), 0);
    chk("t1_rvalid0_off", 32'(bus.rvalid0), 0);

    // 2: tie from reset goes to 0, forced handover after 8 accesses
    do_reset();
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.addr0 = 7'h01; bus.addr1 = 7'h02;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("t2_gnt0_c%0d", k), 32'(bus.gnt0), 1);
      chk($sformatf("t2_gnt1_c%0d", k), 32'(bus.gnt1), 0);
    end
    tick();
    chk("t2_ho_gnt0", 32'(bus.gnt0), 0);
    chk("t2_ho_gnt1", 32'(bus.gnt1), 1);
    chk("t2_ho_rvalid0", 32'(bus.rvalid0), 1);
    chk("t2_ho_rvalid1", 32'(bus.rvalid1), 0);
    idle_inputs();
    tick();
    tick();

    // 3: requester 1 streams 20 writes, no contention
    do_reset();
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = '0; bus.wdata1 = 16'h5000;
    tick();
    for (int i = 0; i < 20; i++) begin
      bus.addr1  = 7'(i);
      bus.wdata1 = 16'(16'h5000 + i);
      #1;
      chk($sformatf("t3_gnt1_%0d", i), 32'(bus.gnt1), 1);
      chk($sformatf("t3_we_%0d", i), 32'(bus.mem_we), 1);
      chk($sformatf("t3_addr_%0d", i), 32'(bus.mem_addr), 32'(i));
      tick();
    end
    bus.req1 = 1'b0; bus.we1 = 1'b0;
    tick();
    chk("t3_gnt1_rel", 32'(bus.gnt1), 0);
    chk("t3_mem0", 32'(mem[0]), 32'h5000);
    chk("t3_mem8", 32'(mem[8]), 32'h5008);
    chk("t3_mem19", 32'(mem[19]), 32'h5013);

    // 4: last access of a forced burst is a read; rvalid1 follows grant move
    bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 7'h40; bus.wdata1 = 16'h6000;
    tick();
    chk("t4_gnt1", 32'(bus.gnt1), 1);
    bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 7'h30; bus.wdata0 = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      if (i < 7) begin
        bus.we1 = 1'b1; bus.addr1 = 7'(7'h40 + i); bus.wdata1 = 16'(16'h6000 + i);
      end else begin
        bus.we1 = 1'b0; bus.addr1 = 7'h10;
      end
      tick();
    end
    chk("t4_gnt1_off", 32'(bus.gnt1), 0);
    chk("t4_gnt0_on", 32'(bus.gnt0), 1);
    chk("t4_rvalid1", 32'(bus.rvalid1), 1);
    chk("t4_rdata", 32'(bus.rdata), 32'h5010);
    chk("t4_rvalid0", 32'(bus.rvalid0), 0);
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 7'h41;
    tick();
    chk("t4_rvalid1_off", 32'(bus.rvalid1), 0);
    chk("t4_rvalid0_wr", 32'(bus.rvalid0), 0);

    // 5: requester 0 drops after 3 accesses while 1 waits
    tick();
    tick();
    bus.req0 = 1'b0;
    #1;
    chk("t5_we_reqlow", 32'(bus.mem_we), 0);
    chk("t5_gnt0_held", 32'(bus.gnt0), 1);
    tick();
    chk("t5_gnt0_rel", 32'(bus.gnt0), 0);
    chk("t5_gnt1", 32'(bus.gnt1), 1);

    // 6: asynchronous reset in the middle of an OWN1 burst (count = 5)
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        bus.we1 = 1'b1; bus.addr1 = 7'(7'h50 + i); bus.wdata1 = 16'(16'h7000 + i);
      end else begin
        bus.we1 = 1'b0; bus.addr1 = 7'h41;
      end
      tick();
    end
    bus.we1 = 1'b1; bus.addr1 = 7'h55; bus.wdata1 = 16'h7005;
    #1;
    chk("t6_pre_gnt1", 32'(bus.gnt1), 1);
    chk("t6_pre_we", 32'(bus.mem_we), 1);
    chk("t6_pre_rvalid1", 32'(bus.rvalid1), 1);
    chk("t6_pre_rdata", 32'(bus.rdata), 32'h6001);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_gnt1", 32'(bus.gnt1), 0);
    chk("t6_rvalid1", 32'(bus.rvalid1), 0);
    chk("t6_rvalid0", 32'(bus.rvalid0), 0);
    chk("t6_mem_we", 32'(bus.mem_we), 0);
    chk("t6_mem_addr", 32'(bus.mem_addr), 0);
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 7'h00;
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_tie_gnt0", 32'(bus.gnt0), 1);
    chk("t6_tie_gnt1", 32'(bus.gnt1), 0);
    chk("t6_mem53", 32'(mem[7'h53]), 32'h7003);
    chk("t6_mem55_untouched", 32'(mem[7'h55]), 32'hA055);
    chk("t5_mem30", 32'(mem[7'h30]), 32'h1234);

    idle_inputs();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
